// File: rtl/arduino_node.sv
// ---------------------------------------------------------------------------
// arduino_node
//
// One node on a simple shared request/response bus. A button press queues a
// request {address, data}. The node sends the frame for one protocol tick and
// then waits up to TIMEOUT ticks for a nonzero answer on the bus. While idle,
// a nonzero value seen on the bus is treated as a request addressed to this
// node. The node echoes it back as {MY_NUMBER, value} for one tick.
//
// All protocol activity advances only on "tick" cycles. A tick is produced
// every DIV clock50 cycles by an internal divider.
//
// Ports
//   clock50         in   1              system clock, rising edge
//   reset_n         in   1              asynchronous active-low reset
//   btnClock        in   1              asynchronous send-request button
//   address         in   ADDR_W         destination of the outgoing request
//   data            in   DATA_W         payload of the outgoing request
//   in              in   DATA_W         incoming bus value, nonzero = valid
//   out             out  ADDR_W+DATA_W  bus frame {addr, data}, zero = idle
//   arduinoResponse out  DATA_W         last accepted incoming value
//   responseDisplay out  ADDR_W+DATA_W  last completed transaction
//   busy            out  1              node is not in IDLE
//   timeout_err     out  1              sticky, last WAIT expired unanswered
// ---------------------------------------------------------------------------
module arduino_node #(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 2,
    parameter int MY_NUMBER = 2,
    parameter int DIV       = 50000,
    parameter int TIMEOUT   = 8
) (
    input  logic                     clock50,
    input  logic                     reset_n,
    input  logic                     btnClock,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        data,
    input  logic [DATA_W-1:0]        in,
    output logic [ADDR_W+DATA_W-1:0] out,
    output logic [DATA_W-1:0]        arduinoResponse,
    output logic [ADDR_W+DATA_W-1:0] responseDisplay,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int DIV_CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TO_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);
    localparam logic [TO_CW-1:0]  TO_LAST  = TO_CW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] MY_ADDR  = ADDR_W'(MY_NUMBER);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_WAIT  = 2'd2,
        S_REPLY = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [DIV_CW-1:0]   div_cnt_q,  div_cnt_d;
    logic [TO_CW-1:0]    wait_cnt_q, wait_cnt_d;

    // Button synchroniser (meta, sync) plus one delayed copy for edge detect.
    logic                btn_meta_q, btn_sync_q, btn_prev_q;

    // Queued request: one slot, captured at the button edge.
    logic                pending_q,  pending_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   data_q,     data_d;

    // Address of the transaction currently in flight. This is kept separate
    // from addr_q so that a press during SEND/WAIT can queue the next request
    // without corrupting the responseDisplay of the current one.
    logic [ADDR_W-1:0]   txn_addr_q, txn_addr_d;

    logic [FRAME_W-1:0]  out_q,      out_d;
    logic [DATA_W-1:0]   resp_q,     resp_d;
    logic [FRAME_W-1:0]  disp_q,     disp_d;
    logic                busy_q,     busy_d;
    logic                terr_q,     terr_d;

    logic                tick;
    logic                btn_edge;
    logic                in_valid;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            wait_cnt_q <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
            pending_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            txn_addr_q <= '0;
            out_q      <= '0;
            resp_q     <= '0;
            disp_q     <= '0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            btn_meta_q <= btnClock;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
            pending_q  <= pending_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            txn_addr_q <= txn_addr_d;
            out_q      <= out_d;
            resp_q     <= resp_d;
            disp_q     <= disp_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pending_d  = pending_q;
        addr_d     = addr_q;
        data_d     = data_q;
        txn_addr_d = txn_addr_q;
        out_d      = out_q;
        resp_d     = resp_q;
        disp_d     = disp_q;
        terr_d     = terr_q;

        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_CW'(1);
        btn_edge  = btn_sync_q & ~btn_prev_q;
        in_valid  = (in != '0);

        // A press is only accepted into an empty slot. A press that arrives
        // while a request is already queued is dropped.
        if (btn_edge && !pending_q) begin
            pending_d = 1'b1;
            addr_d    = address;
            data_d    = data;
        end

        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    // An incoming request takes priority. Any queued send
                    // stays pending until IDLE is seen again. The echoed frame
                    // register itself holds the captured bus value for REPLY.
                    if (in_valid) begin
                        state_d = S_REPLY;
                        out_d   = {MY_ADDR, in};
                        resp_d  = in;
                        disp_d  = {MY_ADDR, in};
                    end else if (pending_q) begin
                        state_d    = S_SEND;
                        pending_d  = 1'b0;
                        txn_addr_d = addr_q;
                        out_d      = {addr_q, data_q};
                        terr_d     = 1'b0;
                    end
                end
                S_SEND: begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                    out_d      = '0;
                end
                S_WAIT: begin
                    if (in_valid) begin
                        state_d = S_IDLE;
                        resp_d  = in;
                        disp_d  = {txn_addr_q, in};
                    end else if (wait_cnt_q == TO_LAST) begin
                        state_d = S_IDLE;
                        terr_d  = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TO_CW'(1);
                    end
                end
                S_REPLY: begin
                    state_d = S_IDLE;
                    out_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    out_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign out             = out_q;
    assign arduinoResponse = resp_q;
    assign responseDisplay = disp_q;
    assign busy            = busy_q;
    assign timeout_err     = terr_q;

endmodule

// File: tb/tb_arduino_node.sv
// ---------------------------------------------------------------------------
// tb_arduino_node
//
// Directed bench for arduino_node with DIV=4, TIMEOUT=3, MY_NUMBER=2 and
// 2-bit address/data. The bench counts clock50 edges since reset release.
// With DIV=4, protocol ticks take effect on edges 4, 8, 12, and so on.
// Every bus frame the DUT should emit is queued ahead of time. A monitor pops
// and compares a queued frame each time the out signal changes.
// ---------------------------------------------------------------------------
module tb_arduino_node;

    logic       clock50 = 1'b0;
    logic       reset_n;
    logic       btnClock;
    logic [1:0] address;
    logic [1:0] data;
    logic [1:0] in_bus;
    logic [3:0] out;
    logic [1:0] arduinoResponse;
    logic [3:0] responseDisplay;
    logic       busy;
    logic       timeout_err;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [3:0] exp_q[$];
    logic [3:0] last_out = 4'h0;

    arduino_node #(
        .ADDR_W   (2),
        .DATA_W   (2),
        .MY_NUMBER(2),
        .DIV      (4),
        .TIMEOUT  (3)
    ) dut (
        .clock50        (clock50),
        .reset_n        (reset_n),
        .btnClock       (btnClock),
        .address        (address),
        .data           (data),
        .in             (in_bus),
        .out            (out),
        .arduinoResponse(arduinoResponse),
        .responseDisplay(responseDisplay),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clock50 = ~clock50;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock50);
        cyc++;
        #1;
    endtask

    task automatic to_edge(input int n);
        while (cyc < n) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"},  {4'h0, out},             8'h00);
        check({tag, "_resp"}, {6'h0, arduinoResponse}, 8'h00);
        check({tag, "_disp"}, {4'h0, responseDisplay}, 8'h00);
        check({tag, "_busy"}, {7'h0, busy},            8'h00);
        check({tag, "_terr"}, {7'h0, timeout_err},     8'h00);
    endtask

    // Scoreboard side: compare each new bus frame against the queue.
    always @(negedge clock50) begin
        if (reset_n === 1'b1 && out !== last_out) begin
            if (exp_q.size() == 0)
                check("out_unexpected_change", {4'h0, out}, {4'h0, last_out});
            else
                check("out_frame", {4'h0, out}, {4'h0, exp_q.pop_front()});
            last_out <= out;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b1;
        btnClock = 1'b0;
        address  = 2'd0;
        data     = 2'd0;
        in_bus   = 2'd0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock50);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        cyc     = 0;

        // Send address=1 data=3 and get the answer 2'b10 on the second WAIT tick.
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0000);
        address  = 2'd1;
        data     = 2'd3;
        btnClock = 1'b1;
        to_edge(3);
        check("A_out_before_send", {4'h0, out}, 8'h00);
        check("A_busy_before_send", {7'h0, busy}, 8'h00);
        to_edge(4);
        check("A_out_send_first", {4'h0, out}, 8'h07);
        check("A_busy_send", {7'h0, busy}, 8'h01);
        check("A_terr_send", {7'h0, timeout_err}, 8'h00);
        to_edge(5);
        btnClock = 1'b0;
        to_edge(7);
        check("A_out_send_last", {4'h0, out}, 8'h07);
        to_edge(8);
        check("A_out_wait", {4'h0, out}, 8'h00);
        check("A_busy_wait", {7'h0, busy}, 8'h01);
        to_edge(12);
        in_bus = 2'b10;
        to_edge(15);
        check("A_busy_wait2", {7'h0, busy}, 8'h01);
        check("A_resp_pending", {6'h0, arduinoResponse}, 8'h00);
        to_edge(16);
        check("A_resp", {6'h0, arduinoResponse}, 8'h02);
        check("A_disp", {4'h0, responseDisplay}, 8'h06);
        check("A_busy_done", {7'h0, busy}, 8'h00);
        check("A_terr_done", {7'h0, timeout_err}, 8'h00);

        // No answer: timeout after three WAIT ticks.
        in_bus   = 2'b00;
        exp_q.push_back(4'b1001);
        exp_q.push_back(4'b0000);
        address  = 2'd2;
        data     = 2'd1;
        btnClock = 1'b1;
        to_edge(21);
        btnClock = 1'b0;
        check("B_out_send", {4'h0, out}, 8'h09);
        to_edge(35);
        check("B_terr_before", {7'h0, timeout_err}, 8'h00);
        check("B_busy_before", {7'h0, busy}, 8'h01);
        to_edge(36);
        check("B_terr_set", {7'h0, timeout_err}, 8'h01);
        check("B_busy_idle", {7'h0, busy}, 8'h00);
        check("B_disp_kept", {4'h0, responseDisplay}, 8'h06);
        check("B_resp_kept", {6'h0, arduinoResponse}, 8'h02);

        // The next press clears timeout_err when SEND is entered.
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b0000);
        address  = 2'd3;
        data     = 2'd2;
        btnClock = 1'b1;
        to_edge(39);
        check("B2_terr_sticky", {7'h0, timeout_err}, 8'h01);
        to_edge(40);
        check("B2_terr_cleared", {7'h0, timeout_err}, 8'h00);
        check("B2_out_send", {4'h0, out}, 8'h0E);
        to_edge(41);
        btnClock = 1'b0;
        to_edge(44);
        in_bus = 2'b10;
        to_edge(48);
        check("B2_resp", {6'h0, arduinoResponse}, 8'h02);
        check("B2_disp", {4'h0, responseDisplay}, 8'h0E);
        in_bus = 2'b00;

        // Incoming request while idle: echo {MY_NUMBER, in} for one tick.
        exp_q.push_back(4'b1001);
        exp_q.push_back(4'b0000);
        to_edge(49);
        in_bus = 2'b01;
        to_edge(52);
        check("C_out_reply", {4'h0, out}, 8'h09);
        check("C_resp", {6'h0, arduinoResponse}, 8'h01);
        check("C_disp", {4'h0, responseDisplay}, 8'h09);
        check("C_busy", {7'h0, busy}, 8'h01);
        in_bus = 2'b00;
        to_edge(55);
        check("C_out_hold", {4'h0, out}, 8'h09);
        to_edge(56);
        check("C_out_back_idle", {4'h0, out}, 8'h00);
        check("C_busy_idle", {7'h0, busy}, 8'h00);

        // Incoming request and a queued press on the same tick: REPLY first.
        // A second press while the first is still queued must be dropped.
        exp_q.push_back(4'b1011);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0110);
        exp_q.push_back(4'b0000);
        address  = 2'd1;
        data     = 2'd2;
        btnClock = 1'b1;
        to_edge(57);
        in_bus = 2'b11;
        to_edge(60);
        check("D_out_reply", {4'h0, out}, 8'h0B);
        check("D_resp", {6'h0, arduinoResponse}, 8'h03);
        in_bus = 2'b00;
        to_edge(61);
        btnClock = 1'b0;
        to_edge(62);
        address  = 2'd3;
        data     = 2'd3;
        btnClock = 1'b1;
        to_edge(63);
        btnClock = 1'b0;
        to_edge(64);
        check("D_out_idle", {4'h0, out}, 8'h00);
        check("D_busy_idle", {7'h0, busy}, 8'h00);
        to_edge(68);
        check("D_out_send", {4'h0, out}, 8'h06);
        check("D_busy_send", {7'h0, busy}, 8'h01);
        to_edge(72);
        check("D_out_wait", {4'h0, out}, 8'h00);

        // Queue another request, then reset during WAIT.
        address  = 2'd2;
        data     = 2'd3;
        btnClock = 1'b1;
        to_edge(73);
        btnClock = 1'b0;
        to_edge(76);
        #3 reset_n = 1'b0;
        #1;
        check_all_zero("E_async_reset");
        repeat (3) @(posedge clock50);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
        to_edge(4);
        check("E_out_after_release", {4'h0, out}, 8'h00);
        check("E_busy_after_release", {7'h0, busy}, 8'h00);
        to_edge(24);
        check_all_zero("E_quiet");

        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
